// File: rtl/led_seq_ctrl_if.sv
// Bundle between the SOC command/config side, the pattern ROM and the
// LED sequencing controller. The controller takes the slave view; the
// SOC logic plus the ROM together form the master view.
interface led_seq_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 5,
    parameter int DIV_W  = 24
);
    logic [ADDR_W-1:0] cfg_start;
    logic [ADDR_W-1:0] cfg_end;
    logic [DIV_W-1:0]  cfg_div;
    logic [1:0]        cfg_mode;
    logic              cmd_start;
    logic              cmd_stop;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_re;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] leds;
    logic              busy;
    logic              done;
    logic              err;

    // Config, commands and ROM read data flow in from the system side.
    modport master (
        output cfg_start, cfg_end, cfg_div, cfg_mode, cmd_start, cmd_stop, rom_data,
        input  rom_addr, rom_re, leds, busy, done, err
    );

    // The controller consumes config/commands and owns the ROM read port.
    modport slave (
        input  cfg_start, cfg_end, cfg_div, cfg_mode, cmd_start, cmd_stop, rom_data,
        output rom_addr, rom_re, leds, busy, done, err
    );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: walks an address window of a synchronous pattern
// ROM in loop, one-shot or bounce order and holds each pattern on the LEDs
// for cfg_div+3 cycles (FETCH 1, LATCH 1, HOLD cfg_div+1).
module led_seq_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 5,
    parameter int DEPTH  = 21,
    parameter int DIV_W  = 24
) (
    input  logic          CLK,
    input  logic          RESET,
    led_seq_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LATCH,
        HOLD
    } state_t;

    typedef enum logic [1:0] {
        MODE_LOOP    = 2'b00,
        MODE_ONESHOT = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    // One extra bit so DEPTH itself is representable in the range check.
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    dir_t              dir_q, dir_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DATA_W-1:0] leds_q, leds_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    // Shadow copy of the configuration taken at an accepted start, so the
    // cfg_* inputs may change freely while a run is in progress.
    logic [ADDR_W-1:0] sh_start_q, sh_start_d;
    logic [ADDR_W-1:0] sh_end_q, sh_end_d;
    logic [DIV_W-1:0]  sh_div_q, sh_div_d;
    mode_t             sh_mode_q, sh_mode_d;

    logic [ADDR_W-1:0] next_addr;
    dir_t              next_dir;
    logic              cfg_bad;

    // Window check for a start request: empty window or end past the ROM.
    assign cfg_bad = (bus.cfg_start > bus.cfg_end) || ({1'b0, bus.cfg_end} >= DEPTH_X);

    // Next address/direction after the current pattern period (loop and bounce).
    always_comb begin
        // NOTE: every combinational output is given a default first, so no
        // path through the block can leave it unassigned and infer a latch.
        next_addr = addr_q + ADDR_ONE;
        next_dir  = dir_q;
        case (sh_mode_q)
            MODE_BOUNCE: begin
                if (sh_start_q == sh_end_q) begin
                    next_addr = addr_q;
                end else if (dir_q == DIR_UP) begin
                    if (addr_q == sh_end_q) begin
                        next_addr = addr_q - ADDR_ONE;
                        next_dir  = DIR_DOWN;
                    end
                end else begin
                    if (addr_q == sh_start_q) begin
                        next_dir = DIR_UP;
                    end else begin
                        next_addr = addr_q - ADDR_ONE;
                    end
                end
            end
            default: begin
                // Loop and reserved wrap to start; the one-shot end is
                // intercepted by the FSM before this value is used.
                if (addr_q == sh_end_q) begin
                    next_addr = sh_start_q;
                end
            end
        endcase
    end

    // FSM next-state, datapath updates and pulse generation.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        dir_d      = dir_q;
        div_d      = div_q;
        leds_d     = leds_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        sh_start_d = sh_start_q;
        sh_end_d   = sh_end_q;
        sh_div_d   = sh_div_q;
        sh_mode_d  = sh_mode_q;

        case (state_q)
            IDLE: begin
                // A stop in the same cycle cancels the start entirely.
                if (bus.cmd_start && !bus.cmd_stop) begin
                    if (cfg_bad) begin
                        err_d = 1'b1;
                    end else begin
                        sh_start_d = bus.cfg_start;
                        sh_end_d   = bus.cfg_end;
                        sh_div_d   = bus.cfg_div;
                        sh_mode_d  = mode_t'(bus.cfg_mode);
                        addr_d     = bus.cfg_start;
                        dir_d      = DIR_UP;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                state_d = bus.cmd_stop ? IDLE : LATCH;
            end
            LATCH: begin
                if (bus.cmd_stop) begin
                    state_d = IDLE;
                end else begin
                    leds_d  = bus.rom_data;
                    div_d   = sh_div_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.cmd_stop) begin
                    state_d = IDLE;
                end else if (div_q != '0) begin
                    div_d = div_q - DIV_ONE;
                end else if (sh_mode_q == MODE_ONESHOT && addr_q == sh_end_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    addr_d  = next_addr;
                    dir_d   = next_dir;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values and updates together at the clock edge.
        if (RESET) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            dir_q      <= DIR_UP;
            div_q      <= '0;
            leds_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sh_start_q <= '0;
            sh_end_q   <= '0;
            sh_div_q   <= '0;
            sh_mode_q  <= MODE_LOOP;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            dir_q      <= dir_d;
            div_q      <= div_d;
            leds_q     <= leds_d;
            done_q     <= done_d;
            err_q      <= err_d;
            sh_start_q <= sh_start_d;
            sh_end_q   <= sh_end_d;
            sh_div_q   <= sh_div_d;
            sh_mode_q  <= sh_mode_d;
        end
    end

    // A stop arriving during FETCH suppresses the read it would have issued.
    assign bus.rom_re   = (state_q == FETCH) && !bus.cmd_stop;
    assign bus.rom_addr = addr_q;
    assign bus.leds     = leds_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl: directed scenarios followed by
// randomized runs, all compared cycle by cycle against a timeline model
// derived from the pattern period and the address order of each mode.
module tb_led_seq_ctrl;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 5;
    localparam int DEPTH  = 21;
    localparam int DIV_W  = 24;

    logic CLK;
    logic RESET;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] rom [0:31];
    logic [DATA_W-1:0] model_leds;

    led_seq_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

    led_seq_ctrl #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous pattern ROM: data valid the cycle after the read enable.
    initial bus.rom_data = '0;
    always @(posedge CLK) begin
        if (bus.rom_re) bus.rom_data <= rom[bus.rom_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Address of the j-th pattern shown in a run, from the mode's ordering rule.
    function automatic logic [ADDR_W-1:0] seq_addr(input int s, input int e, input int m, input int j);
        int n, l, r;
        n = e - s + 1;
        if (m == 1) return ADDR_W'(s + j);
        if (m == 2) begin
            if (n == 1) return ADDR_W'(s);
            l = 2 * (n - 1);
            r = j % l;
            return (r < n) ? ADDR_W'(s + r) : ADDR_W'(s + l - r);
        end
        return ADDR_W'(s + (j % n));
    endfunction

    // Issue one start at the current cycle t and check cycles t+1 .. term+4.
    // stop_at / rst_at are cycle offsets from t (0 = none).
    task automatic run(input int s, input int e, input int d, input int m,
                       input int stop_at, input int rst_at, input bit disturb);
        bit valid, os_end, act;
        int n, p, term, ncyc, limit, k, ph, j;
        logic [DATA_W-1:0] exp_leds;
        valid  = (s <= e) && (e < DEPTH);
        n      = e - s + 1;
        p      = d + 3;
        term   = 1 << 30;
        os_end = 1'b0;
        if (m == 1) begin
            term   = n * p;
            os_end = 1'b1;
        end
        if (stop_at > 0 && stop_at <= term) begin
            term   = stop_at;
            os_end = 1'b0;
        end
        if (rst_at > 0 && rst_at <= term) begin
            term   = rst_at;
            os_end = 1'b0;
        end
        ncyc     = valid ? term + 4 : 4;
        exp_leds = model_leds;

        bus.cfg_start = ADDR_W'(s);
        bus.cfg_end   = ADDR_W'(e);
        bus.cfg_div   = DIV_W'(d);
        bus.cfg_mode  = 2'(m);
        bus.cmd_start = 1'b1;
        @(negedge CLK);
        bus.cmd_start = 1'b0;

        for (int c = 1; c <= ncyc; c++) begin
            act = valid && (c <= term);
            ph  = (c - 1) % p;
            j   = (c - 1) / p;
            if (rst_at > 0 && c > rst_at) begin
                exp_leds = '0;
            end else if (!valid) begin
                exp_leds = model_leds;
            end else begin
                limit = c - 1;
                if (!os_end && term - 1 < limit) limit = term - 1;
                if (os_end && term < limit) limit = term;
                k = (limit >= 2) ? (limit - 2) / p + 1 : 0;
                exp_leds = (k > 0) ? rom[seq_addr(s, e, m, k - 1)] : model_leds;
            end
            check($sformatf("leds c%0d", c), 32'(bus.leds), 32'(exp_leds));
            check($sformatf("busy c%0d", c), 32'(bus.busy), 32'(act));
            check($sformatf("done c%0d", c), 32'(bus.done), 32'(valid && os_end && c == term + 1));
            check($sformatf("err c%0d", c), 32'(bus.err), 32'(!valid && c == 1));
            if (c != stop_at) begin
                check($sformatf("rom_re c%0d", c), 32'(bus.rom_re), 32'(act && ph == 0));
                if (act && ph == 0)
                    check($sformatf("rom_addr c%0d", c), 32'(bus.rom_addr), 32'(seq_addr(s, e, m, j)));
            end

            bus.cmd_stop  = (c == stop_at);
            RESET         = (c == rst_at);
            bus.cmd_start = 1'b0;
            if (disturb) begin
                if (act && c != stop_at && c != rst_at && $urandom_range(0, 3) == 0)
                    bus.cmd_start = 1'b1;
                if ($urandom_range(0, 2) == 0) begin
                    bus.cfg_start = ADDR_W'($urandom);
                    bus.cfg_end   = ADDR_W'($urandom);
                    bus.cfg_div   = DIV_W'($urandom);
                    bus.cfg_mode  = 2'($urandom);
                end
            end
            @(negedge CLK);
        end
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        RESET         = 1'b0;
        model_leds    = exp_leds;
    endtask

    // Start and stop together while idle must cause no activity at all.
    task automatic idle_start_stop();
        bus.cfg_start = 5'd1;
        bus.cfg_end   = 5'd4;
        bus.cfg_div   = '0;
        bus.cfg_mode  = 2'b00;
        bus.cmd_start = 1'b1;
        bus.cmd_stop  = 1'b1;
        @(negedge CLK);
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("ss busy c%0d", c), 32'(bus.busy), 32'd0);
            check($sformatf("ss err c%0d", c), 32'(bus.err), 32'd0);
            check($sformatf("ss rom_re c%0d", c), 32'(bus.rom_re), 32'd0);
            check($sformatf("ss leds c%0d", c), 32'(bus.leds), 32'(model_leds));
            @(negedge CLK);
        end
    endtask

    initial begin
        int s, e, d, m, n, p, stop, rst, sel;
        RESET         = 1'b1;
        bus.cfg_start = '0;
        bus.cfg_end   = '0;
        bus.cfg_div   = '0;
        bus.cfg_mode  = '0;
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = DATA_W'(i);
        model_leds = '0;

        @(negedge CLK);
        check("rst leds", 32'(bus.leds), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst rom_re", 32'(bus.rom_re), 32'd0);
        check("rst rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst err", 32'(bus.err), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        // Loop timing, one-shot, bounce and single-entry bounce.
        run(2, 4, 0, 0, 14, 0, 1'b0);
        run(0, 2, 1, 1, 0, 0, 1'b0);
        run(1, 3, 0, 2, 22, 0, 1'b0);
        run(5, 5, 0, 2, 10, 0, 1'b0);
        run(5, 5, 2, 1, 0, 0, 1'b0);
        run(3, 6, 0, 3, 20, 0, 1'b0);
        // Rejected starts.
        run(7, 3, 0, 0, 0, 0, 1'b0);
        run(0, 21, 0, 0, 0, 0, 1'b0);
        idle_start_stop();
        // Starts and config changes while busy are ignored.
        run(0, 4, 1, 1, 0, 0, 1'b1);
        // Stop during HOLD of address 3 in one-shot: no done, leds keep ROM[3].
        run(0, 5, 2, 1, 19, 0, 1'b0);
        // Reset during HOLD of a full-window loop.
        run(0, 20, 5, 0, 0, 20, 1'b0);

        for (int i = 0; i < 32; i++) rom[i] = DATA_W'($urandom);
        for (int r = 0; r < 40; r++) begin
            sel = $urandom_range(0, 9);
            e   = $urandom_range(0, 20);
            s   = $urandom_range(0, e);
            if (sel == 0) begin
                s = $urandom_range(1, 31);
                e = $urandom_range(0, s - 1);
            end else if (sel == 1) begin
                e = $urandom_range(21, 31);
                s = $urandom_range(0, e);
            end
            d    = $urandom_range(0, 6);
            m    = $urandom_range(0, 3);
            n    = e - s + 1;
            p    = d + 3;
            stop = (n > 0) ? $urandom_range(1, p * (2 * n + 2)) : 1;
            rst  = 0;
            if ($urandom_range(0, 4) == 0) begin
                rst  = stop;
                stop = 0;
            end
            if (m == 1 && $urandom_range(0, 1) == 1) begin
                stop = 0;
                rst  = 0;
            end
            if (sel <= 1) begin
                stop = 0;
                rst  = 0;
            end
            run(s, e, d, m, stop, rst, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
